// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode constants,
// address-width derivation and the almost-flag threshold comparisons.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // RAM address width for a given entry count.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Almost-flag threshold checks on an occupancy value.
  function automatic logic at_or_above(input int unsigned lvl, input int unsigned th);
    return lvl >= th;
  endfunction

  function automatic logic at_or_below(input int unsigned lvl, input int unsigned th);
    return lvl <= th;
  endfunction

endpackage

// File: rtl/ad_mem.sv
// Simple dual-port RAM: write port A, registered read port B.
module ad_mem #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clka,
  input  logic                     wea,
  input  logic [ADDRESS_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic                     clkb,
  input  logic                     reb,
  input  logic [ADDRESS_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb
);

  logic [DATA_WIDTH-1:0] m_ram [0:(2**ADDRESS_WIDTH)-1];

  // Write port.
  always_ff @(posedge clka) begin
    if (wea) m_ram[addra] <= dina;
  end

  // Registered read port; output holds between read enables.
  always_ff @(posedge clkb) begin
    if (reb) doutb <= m_ram[addrb];
  end

endmodule

// File: rtl/fifo_fwft_out.sv
// First-word-fall-through output stage. The RAM read register acts as a
// prefetch slot in front of the output holding register, so a continuous
// pop stream is served without bubbles.
module fifo_fwft_out #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             pop,
  input  logic             mem_avail,
  input  logic [WIDTH-1:0] mem_dout,
  output logic             mem_ren,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  logic dout_vld;
  logic load;

  // Move the prefetched word forward when the output slot is free or being
  // popped; refill the prefetch slot whenever it is (or becomes) empty.
  always_comb begin
    load    = dout_vld & (~valid | pop);
    mem_ren = ~sclr & mem_avail & (~dout_vld | load);
  end

  // Output register, its valid bit and the prefetch-slot valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      dout_vld <= 1'b0;
      rdata    <= '0;
    end else if (sclr) begin
      valid    <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      if (load) begin
        rdata <= mem_dout;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (mem_ren)   dout_vld <= 1'b1;
      else if (load) dout_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or FWFT read mode, exact occupancy,
// programmable almost flags, sticky error flags and synchronous flush.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = FIFO_STD,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 2,
  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclr,
  input  logic                  winc,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  wfull,
  output logic                  almost_full,
  input  logic                  rinc,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rempty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned         LW       = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]       LVL_FULL = LW'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH=%0d must be a power of 2 and >= 4", DEPTH);
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_TH=%0d outside 1..DEPTH", AFULL_TH);
  end
  if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_TH=%0d outside 0..DEPTH-1", AEMPTY_TH);
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("sync_fifo_flex: FWFT=%0d is not a valid read mode", FWFT);
  end

  logic [LW-1:0]    wptr;
  logic [LW-1:0]    rptr;
  logic [LW-1:0]    level_next;
  logic             wr_ok;
  logic             rd_ok;
  logic             mem_ren;
  logic             mem_avail;
  logic [WIDTH-1:0] mem_dout;

  // Accept qualification and next occupancy; flush overrides both requests.
  always_comb begin
    wr_ok      = winc & ~wfull & ~sclr;
    rd_ok      = rinc & ~rempty & ~sclr;
    mem_avail  = (wptr != rptr);
    level_next = level;
    if (sclr)                level_next = '0;
    else if (wr_ok && !rd_ok) level_next = level + LW'(1);
    else if (rd_ok && !wr_ok) level_next = level - LW'(1);
  end

  // RAM write/read pointers; rptr follows RAM reads, which in FWFT mode are
  // prefetches rather than pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (sclr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok)   wptr <= wptr + LW'(1);
      if (mem_ren) rptr <= rptr + LW'(1);
    end
  end

  // Occupancy and level-derived flags, registered from level_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level        <= '0;
      wfull        <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_next;
      wfull        <= (level_next == LVL_FULL);
      almost_full  <= at_or_above(32'(level_next), AFULL_TH);
      almost_empty <= at_or_below(32'(level_next), AEMPTY_TH);
    end
  end

  // Sticky error flags; a new error in the same cycle wins over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (winc & wfull & ~sclr)  | (overflow  & ~clr_err);
      underflow <= (rinc & rempty & ~sclr) | (underflow & ~clr_err);
    end
  end

  ad_mem #(
    .DATA_WIDTH    (WIDTH),
    .ADDRESS_WIDTH (ADDR_WIDTH)
  ) i_mem (
    .clka  (clk),
    .wea   (wr_ok),
    .addra (wptr[ADDR_WIDTH-1:0]),
    .dina  (wdata),
    .clkb  (clk),
    .reb   (mem_ren),
    .addrb (rptr[ADDR_WIDTH-1:0]),
    .doutb (mem_dout)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    logic out_valid;

    fifo_fwft_out #(
      .WIDTH (WIDTH)
    ) u_fwft_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclr      (sclr),
      .pop       (rd_ok),
      .mem_avail (mem_avail),
      .mem_dout  (mem_dout),
      .mem_ren   (mem_ren),
      .rdata     (rdata),
      .valid     (out_valid)
    );

    assign rempty = ~out_valid;
  end else begin : g_std
    logic rd_pend;

    // rd_ok already implies a stored word; mem_avail is a redundant guard.
    assign mem_ren = rd_ok & mem_avail;

    // Empty flag plus second-stage read register fed by the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rempty  <= 1'b1;
        rd_pend <= 1'b0;
        rdata   <= '0;
      end else begin
        rempty  <= (level_next == '0);
        rd_pend <= rd_ok;
        if (rd_pend && !sclr) rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: one standard-mode and one FWFT
// instance, each checked against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int unsigned D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_sclr = 0, s_winc = 0, s_rinc = 0, s_clr = 0;
  logic [7:0] s_wdata = '0, s_rdata;
  logic       s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf;
  logic [4:0] s_level;

  logic       f_sclr = 0, f_winc = 0, f_rinc = 0, f_clr = 0;
  logic [7:0] f_wdata = '0, f_rdata;
  logic       f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_unf;
  logic [4:0] f_level;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .sclr(s_sclr), .winc(s_winc), .wdata(s_wdata),
    .wfull(s_wfull), .almost_full(s_afull), .rinc(s_rinc), .rdata(s_rdata),
    .rempty(s_rempty), .almost_empty(s_aempty), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .sclr(f_sclr), .winc(f_winc), .wdata(f_wdata),
    .wfull(f_wfull), .almost_full(f_afull), .rinc(f_rinc), .rdata(f_rdata),
    .rempty(f_rempty), .almost_empty(f_aempty), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] sq[$];
  logic [7:0] fq[$];
  logic [7:0] s_exp_rdata = '0;
  logic       s_pend_v = 0;
  logic [7:0] s_pend_w = '0;
  logic       s_exp_ovf = 0, s_exp_unf = 0, f_exp_ovf = 0, f_exp_unf = 0;

  task automatic model_reset();
    sq.delete(); fq.delete();
    s_exp_rdata = '0; s_pend_v = 0;
    s_exp_ovf = 0; s_exp_unf = 0; f_exp_ovf = 0; f_exp_unf = 0;
  endtask

  // One clock of the standard instance: drive at negedge, update the model
  // at posedge, return at the following negedge.
  task automatic s_step(input logic w, input logic [7:0] d, input logic r,
                        input logic sc, input logic ce);
    int unsigned sz;
    logic aw, ar, so, su;
    sz = sq.size();
    aw = w & ~sc & (sz < D);
    ar = r & ~sc & (sz != 0);
    so = w & ~sc & (sz == D);
    su = r & ~sc & (sz == 0);
    s_winc = w; s_wdata = d; s_rinc = r; s_sclr = sc; s_clr = ce;
    @(posedge clk);
    if (sc) begin
      sq.delete(); s_pend_v = 0;
    end else begin
      if (s_pend_v) s_exp_rdata = s_pend_w;
      s_pend_v = ar;
      if (ar) s_pend_w = sq.pop_front();
      if (aw) sq.push_back(d);
    end
    s_exp_ovf = so | (s_exp_ovf & ~ce);
    s_exp_unf = su | (s_exp_unf & ~ce);
    @(negedge clk);
    s_winc = 0; s_rinc = 0; s_sclr = 0; s_clr = 0;
  endtask

  // One clock of the FWFT instance; a pop is accepted whenever a word is shown.
  task automatic f_step(input logic w, input logic [7:0] d, input logic r,
                        input logic sc, input logic ce);
    int unsigned sz;
    logic aw, ar, so, su;
    sz = fq.size();
    aw = w & ~sc & (sz < D);
    ar = r & ~sc & ~f_rempty;
    so = w & ~sc & (sz == D);
    su = r & ~sc & f_rempty;
    f_winc = w; f_wdata = d; f_rinc = r; f_sclr = sc; f_clr = ce;
    @(posedge clk);
    if (sc) fq.delete();
    else begin
      if (ar && fq.size() > 0) void'(fq.pop_front());
      if (aw) fq.push_back(d);
    end
    f_exp_ovf = so | (f_exp_ovf & ~ce);
    f_exp_unf = su | (f_exp_unf & ~ce);
    @(negedge clk);
    f_winc = 0; f_rinc = 0; f_sclr = 0; f_clr = 0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({s_level, s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf, s_rdata} !==
        {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_std: got %h expected %h",
               {s_level, s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf, s_rdata},
               {5'd0, 6'b001100, 8'h00});
    end
    n_vec++;
    if ({f_level, f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_unf, f_rdata} !==
        {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_fwft: got %h expected %h",
               {f_level, f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_unf, f_rdata},
               {5'd0, 6'b001100, 8'h00});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain_std();
    for (int i = 0; i < 16; i++) begin
      s_step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({s_level, s_wfull, s_afull, s_rempty} !== {5'(i + 1), i == 15, (i + 1) >= 14, 1'b0}) begin
        n_err++;
        $display("FAIL fill[%0d]: got lvl/full/afull/empty %h expected %h", i,
                 {s_level, s_wfull, s_afull, s_rempty}, {5'(i + 1), i == 15, (i + 1) >= 14, 1'b0});
      end
    end
    for (int i = 0; i < 16; i++) begin
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ({s_rdata, s_level, s_rempty, s_aempty, s_wfull} !==
          {(i == 0) ? 8'h00 : 8'(i - 1), 5'(15 - i), i == 15, (15 - i) <= 2, 1'b0}) begin
        n_err++;
        $display("FAIL drain[%0d]: got rdata/lvl/empty/aempty/full %h expected %h", i,
                 {s_rdata, s_level, s_rempty, s_aempty, s_wfull},
                 {(i == 0) ? 8'h00 : 8'(i - 1), 5'(15 - i), i == 15, (15 - i) <= 2, 1'b0});
      end
    end
    for (int i = 0; i < 2; i++) begin
      s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({s_rdata, s_rempty} !== {8'h0F, 1'b1}) begin
        n_err++;
        $display("FAIL drain_last: got rdata %h empty %b expected 0f 1", s_rdata, s_rempty);
      end
    end
  endtask

  task automatic test_overflow_std();
    for (int i = 0; i < 16; i++) s_step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    s_step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({s_level, s_wfull, s_ovf, s_unf} !== {5'd15, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_full_rw: got lvl/full/ovf/unf %h expected %h",
               {s_level, s_wfull, s_ovf, s_unf}, {5'd15, 3'b010});
    end
    s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (s_rdata !== 8'h10) begin
      n_err++; $display("FAIL ovf_rdata: got %h expected 10", s_rdata);
    end
    s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (s_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr: got %b expected 0", s_ovf);
    end
    s_step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    s_step(1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({s_ovf, s_wfull, s_level} !== {1'b1, 1'b1, 5'd16}) begin
      n_err++;
      $display("FAIL ovf_set_beats_clr: got ovf/full/lvl %h expected %h",
               {s_ovf, s_wfull, s_level}, {2'b11, 5'd16});
    end
    s_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({s_ovf, s_level, s_wfull, s_rempty} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL sclr_keeps_ovf: got %h expected %h",
               {s_ovf, s_level, s_wfull, s_rempty}, {1'b1, 5'd0, 2'b01});
    end
    s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow_std();
    s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({s_unf, s_level, s_rempty} !== {1'b1, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL unf_empty_rd: got unf/lvl/empty %h expected %h",
               {s_unf, s_level, s_rempty}, {1'b1, 5'd0, 1'b1});
    end
    s_step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({s_level, s_rempty, s_unf} !== {5'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL unf_rw_empty: got lvl/empty/unf %h expected %h",
               {s_level, s_rempty, s_unf}, {5'd1, 2'b01});
    end
    s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({s_unf, s_rdata, s_rempty} !== {1'b0, 8'h5A, 1'b1}) begin
      n_err++;
      $display("FAIL unf_clr_read: got unf/rdata/empty %h expected %h",
               {s_unf, s_rdata, s_rempty}, {1'b0, 8'h5A, 1'b1});
    end
  endtask

  task automatic test_wrap_std();
    for (int i = 0; i < 3; i++) s_step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      s_step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ({s_level, s_wfull, s_afull, s_rempty, s_aempty, s_rdata} !==
          {5'd3, 1'b0, 1'b0, 1'b0, 1'b0, s_exp_rdata}) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h expected %h", i,
                 {s_level, s_wfull, s_afull, s_rempty, s_aempty, s_rdata},
                 {5'd3, 4'b0000, s_exp_rdata});
      end
    end
  endtask

  task automatic test_sclr_std();
    s_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) s_step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({s_level, s_rdata} !== {5'd9, 8'h30}) begin
      n_err++;
      $display("FAIL sclr_pre: got lvl/rdata %h expected %h", {s_level, s_rdata}, {5'd9, 8'h30});
    end
    s_step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({s_level, s_rempty, s_wfull, s_aempty, s_afull, s_rdata, s_ovf, s_unf} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, s_exp_ovf, s_exp_unf}) begin
      n_err++;
      $display("FAIL sclr: got %h expected %h",
               {s_level, s_rempty, s_wfull, s_aempty, s_afull, s_rdata, s_ovf, s_unf},
               {5'd0, 4'b1010, 8'h30, s_exp_ovf, s_exp_unf});
    end
  endtask

  task automatic test_fwft_latency();
    f_step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({f_rempty, f_level} !== {1'b1, 5'd1}) begin
      n_err++; $display("FAIL fwft_k: got empty/lvl %h expected %h", {f_rempty, f_level}, {1'b1, 5'd1});
    end
    f_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (f_rempty !== 1'b1) begin
      n_err++; $display("FAIL fwft_k1: got empty %b expected 1", f_rempty);
    end
    f_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({f_rempty, f_rdata} !== {1'b0, 8'hA5}) begin
      n_err++; $display("FAIL fwft_k2: got empty/rdata %h expected %h", {f_rempty, f_rdata}, {1'b0, 8'hA5});
    end
    f_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({f_rempty, f_level} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL fwft_pop1: got empty/lvl %h expected %h", {f_rempty, f_level}, {1'b1, 5'd0});
    end
    for (int i = 1; i <= 4; i++) f_step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    repeat (3) f_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({f_rempty, f_rdata} !== {1'b0, 8'(i + 1)}) begin
        n_err++;
        $display("FAIL fwft_stream[%0d]: got empty/rdata %h expected %h", i,
                 {f_rempty, f_rdata}, {1'b0, 8'(i + 1)});
      end
      f_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_vec++;
    if ({f_rempty, f_level, f_unf} !== {1'b1, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL fwft_drained: got empty/lvl/unf %h expected %h", {f_rempty, f_level, f_unf}, {1'b1, 5'd0, 1'b0});
    end
  endtask

  task automatic test_random_std();
    int unsigned sz, wp;
    logic [18:0] act, exp;
    for (int i = 0; i < 400; i++) begin
      wp = (i % 100 < 50) ? 75 : 25;
      s_step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 100 - wp,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      sz  = sq.size();
      act = {s_level, s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf, s_rdata};
      exp = {5'(sz), sz == D, sz >= 14, sz == 0, sz <= 2, s_exp_ovf, s_exp_unf, s_exp_rdata};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL rand_std[%0d]: got lvl/full/afull/empty/aempty/ovf/unf/rdata %h expected %h", i, act, exp);
      end
    end
  endtask

  task automatic test_random_fwft();
    int unsigned sz, wp;
    logic [9:0] act, exp;
    for (int i = 0; i < 400; i++) begin
      wp = (i % 100 < 50) ? 75 : 25;
      f_step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 100 - wp,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      sz  = fq.size();
      act = {f_level, f_wfull, f_afull, f_aempty, f_ovf, f_unf};
      exp = {5'(sz), sz == D, sz >= 14, sz <= 2, f_exp_ovf, f_exp_unf};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL rand_fwft[%0d]: got lvl/full/afull/aempty/ovf/unf %h expected %h", i, act, exp);
      end
      n_vec++;
      if (sz == 0 && f_rempty !== 1'b1) begin
        n_err++; $display("FAIL rand_fwft_empty[%0d]: got rempty %b expected 1", i, f_rempty);
      end else if (sz > 0 && f_rempty === 1'b0 && f_rdata !== fq[0]) begin
        n_err++; $display("FAIL rand_fwft_head[%0d]: got rdata %h expected %h", i, f_rdata, fq[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    s_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    s_step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    s_step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    repeat (3) s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    s_step(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) f_step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({s_level, s_rdata, s_unf} !== {5'd1, 8'h62, 1'b1}) begin
      n_err++;
      $display("FAIL arst_pre: got lvl/rdata/unf %h expected %h", {s_level, s_rdata, s_unf}, {5'd1, 8'h62, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_level, s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf, s_rdata} !==
        {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL arst_std: got %h expected %h",
               {s_level, s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf, s_rdata},
               {5'd0, 6'b001100, 8'h00});
    end
    n_vec++;
    if ({f_level, f_rempty, f_aempty, f_rdata} !== {5'd0, 1'b1, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL arst_fwft: got %h expected %h",
               {f_level, f_rempty, f_aempty, f_rdata}, {5'd0, 2'b11, 8'h00});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_drain_std();
    test_overflow_std();
    test_underflow_std();
    test_wrap_std();
    test_sclr_std();
    test_fwft_latency();
    test_random_std();
    test_random_fwft();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO for intra-domain buffering between encoder pipeline stages. It complements the dual-clock FIFO.
- Adds the following, none of which the dual-clock FIFO has:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - exact occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous flush
- Storage is the existing ad_mem dual-port RAM, with both ports on the same clock.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and ≥4. ADDR_WIDTH = $clog2(DEPTH).
- FWFT, 0: read mode. 0 = standard: rdata is valid the cycle after an accepted read. 1 = first-word-fall-through: the head word is presented on rdata while rempty=0.
- AFULL_TH, DEPTH-2: almost_full asserts when level ≥ AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when level ≤ AEMPTY_TH. Legal range 0..DEPTH-1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- sclr, in, 1: synchronous flush; takes priority over winc and rinc.
- winc, in, 1: write request.
- wdata, in, WIDTH: write data.
- wfull, out, 1: registered full flag.
- almost_full, out, 1: registered; level ≥ AFULL_TH.
- rinc, in, 1: read request in standard mode; pop/acknowledge in FWFT mode.
- rdata, out, WIDTH: read data.
- rempty, out, 1: registered empty flag. In FWFT mode it means no valid word is on rdata.
- almost_empty, out, 1: registered; level ≤ AEMPTY_TH.
- level, out, ADDR_WIDTH+1: number of entries accepted and not yet popped, 0..DEPTH.
- overflow, out, 1: sticky; set by winc while wfull.
- underflow, out, 1: sticky; set by rinc while rempty.
- clr_err, in, 1: synchronous clear of overflow and underflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pointers, level and rdata = 0; wfull = 0; rempty = 1; almost_full = 0; almost_empty = 1; overflow = 0; underflow = 0.
  - Reset asserted mid-operation discards all contents immediately.
- Accept conditions: wr_ok = winc & ~wfull; rd_ok = rinc & ~rempty.
  - Binary pointers are ADDR_WIDTH+1 bits and wrap modulo 2·DEPTH.
  - The RAM address is the pointer's low ADDR_WIDTH bits.
- Level: level_next = level + wr_ok − rd_ok.
  - Simultaneous wr_ok and rd_ok leave level unchanged.
  - level never exceeds DEPTH and never underflows.
- Flag timing: wfull, almost_full and almost_empty are registered from level_next, so they are exact on the edge after the event, with no extra lag.
  - wfull = (level_next == DEPTH).
- Write when full: winc with wfull=1 is dropped and sets overflow. A simultaneous rinc is still accepted, and wfull drops next cycle.
- Read when empty: rinc with rempty=1 is ignored and sets underflow. A simultaneous winc is still accepted.
- Standard mode (FWFT=0):
  - rempty = (level_next == 0), registered.
  - rd_ok at edge k → rdata holds the popped word after edge k+1 and keeps it until the next rd_ok.
  - Write at edge k into an empty FIFO → rempty = 0 after edge k.
- FWFT mode (FWFT=1):
  - Uses an output holding register plus valid bit; rempty = ~valid.
  - Write at edge k into an empty FIFO → rdata = that word and rempty = 0 after edge k+2 (RAM write, then prefetch).
  - rd_ok pops the head. If more words are stored, the next word appears without a bubble (prefetch pipelined); otherwise rempty = 1 after the edge.
  - level counts the word held in the output register.
  - Capacity remains DEPTH.
- sclr:
  - At the edge: pointers and level go to 0, FWFT valid clears, flags return to their reset values.
  - rdata holds its last value.
  - overflow and underflow are unaffected.
  - winc and rinc in the same cycle are ignored.
- Error flags: clr_err clears overflow and underflow. A new set event in the same cycle wins over clr_err.
- Parameter errors: illegal DEPTH or thresholds → $error at elaboration.

Decomposition:
- Shared package fifo_pkg holds:
  - a function for the almost-flag threshold checks
  - a localparam function computing ADDR_WIDTH
  - mode constants FIFO_STD and FIFO_FWFT
- Sub-module fifo_fwft_out: the FWFT prefetch/output register stage, generated only when FWFT=1.
- Memory is instantiated from the existing ad_mem.

Test Plan:
- WIDTH=8, DEPTH=16, FWFT=0: write 0x00..0x0F → wfull=1 after 16th edge, level=16, almost_full=1 from level 14. Then 16 reads return 0x00..0x0F in order, with rdata one cycle after each rinc. rempty=1 after the last.
- Full FIFO, winc+rinc in the same cycle → write dropped, overflow=1, level=15, wfull=0 next cycle. clr_err → overflow=0.
- FWFT=1, empty: write 0xA5 at edge k → rdata=0xA5 and rempty=0 after edge k+2. Back-to-back writes 0x01..0x04 then continuous rinc → 0x01..0x04 with no bubble; rempty=1 after the 4th pop.
- Pointer wrap: 40 interleaved write/read pairs at level 3 → data order preserved, level stays 3, no flag glitch.
- Mid-stream sclr at level 9 → level=0, rempty=1, wfull=0 next cycle. rst_n pulsed low asynchronously between edges → outputs reach reset values immediately.
- rinc on empty → underflow=1, level stays 0. Simultaneous winc → level=1.
